if_fetch: RTL
=============

IF_FETCH -- requirements
Module: if_fetch

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 2, giving the instruction buffer depth and the maximum number of outstanding fetches; legal values are 2 and 4.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-004 SHALL have port pc_i, input, 32 bits: fetch address from the PC register.
REQ-005 SHALL have port pc_valid_i, input, 1 bit: pc_i is valid.
REQ-006 SHALL have port pc_ready_o, output, 1 bit: pc_i is consumed this cycle; this is the PC-advance enable.
REQ-007 SHALL have port imem_req_o, output, 1 bit: instruction memory read request.
REQ-008 SHALL have port imem_addr_o, output, 32 bits: word-aligned read address.
REQ-009 SHALL have port imem_gnt_i, input, 1 bit: memory accepts the request this cycle.
REQ-010 SHALL have port imem_rvalid_i, input, 1 bit: read data valid; responses return in order, at least 1 cycle after the grant.
REQ-011 SHALL have port imem_rdata_i, input, 32 bits: returned instruction.
REQ-012 SHALL have port flush_i, input, 1 bit: branch/jump redirect; discard all fetched and in-flight instructions.
REQ-013 SHALL have port inst_valid_o, output, 1 bit: inst_o and inst_pc_o are valid for decode.
REQ-014 SHALL have port inst_o, output, 32 bits: instruction to decode.
REQ-015 SHALL have port inst_pc_o, output, 32 bits: PC of inst_o.
REQ-016 SHALL have port id_ready_i, input, 1 bit: decode accepts inst_o this cycle.

Function
REQ-017 SHALL drive imem_req_o = pc_valid_i & ~flush_i & (outstanding + buf_count < FIFO_DEPTH).
REQ-018 SHALL drive imem_addr_o = {pc_i[31:2], 2'b00}, combinationally.
REQ-019 SHALL drive pc_ready_o = imem_req_o & imem_gnt_i; a grant increments outstanding and pushes pc_i into the tag queue.
REQ-020 SHALL, on imem_rvalid_i with outstanding > 0, pop the tag queue and decrement outstanding; if drop_cnt > 0, decrement drop_cnt and discard the data, otherwise push {tag PC, imem_rdata_i} into the instruction buffer.
REQ-021 SHALL ignore imem_rvalid_i when outstanding == 0 (protocol violation; no state change).
REQ-022 SHALL drive inst_valid_o = (buf_count != 0); inst_o and inst_pc_o come from the buffer head and are forced to 0 when the buffer is empty.
REQ-023 SHALL pop the buffer head when inst_valid_o & id_ready_i; a push and a pop in the same cycle leave buf_count unchanged.
REQ-024 SHALL guarantee, by the credit rule of REQ-017, that outstanding + buf_count <= FIFO_DEPTH at all times; the buffer never overflows.
REQ-025 SHALL, on flush_i, empty the buffer the next cycle and set drop_cnt = outstanding after this cycle's retirement (rvalid in the flush cycle counts as retired and dropped).
REQ-026 SHALL hold inst_valid_o low in the cycle after flush_i unless new data arrives for a post-flush request.
REQ-027 SHALL, when flush_i and id_ready_i are both high in the same cycle, apply the flush and not count the pop as an accepted instruction.
REQ-028 SHALL wrap the buffer and tag-queue read/write pointers modulo FIFO_DEPTH.
REQ-029 SHALL size counters so outstanding and drop_cnt range 0..FIFO_DEPTH.
REQ-030 SHALL have latency: grant at cycle N, rvalid at N+k, inst_valid_o high at N+k+1.

Reset
REQ-031 SHALL, while rst_n = 0, asynchronously clear outstanding, drop_cnt, buf_count and all pointers, giving imem_req_o = 0, pc_ready_o = 0, inst_valid_o = 0, inst_o = 0 and inst_pc_o = 0.
REQ-032 SHALL treat reset during in-flight fetches as abandoning them; the memory is reset by the same rst_n.

Structure
REQ-033 SHALL take the bus widths (InstAddrBus, InstBus), ZeroAddr and RstEnable from the shared defines file; no local redefinition.
REQ-034 SHALL implement both the tag queue and the instruction buffer as two instances of one synchronous FIFO sub-module, fetch_fifo, parameterised by width and depth.

Verification
REQ-035 SHALL cover back-to-back fetch: pc_i 0x0, 0x4, 0x8, gnt always 1, rvalid 1 cycle later, id_ready 1 -> inst_pc_o sequence 0x0, 0x4, 0x8 with matching rdata and no bubbles after the first.
REQ-036 SHALL cover decode stall: id_ready_i = 0 for 5 cycles, DEPTH = 2 -> exactly 2 grants, imem_req_o = 0 thereafter, no data lost on release.
REQ-037 SHALL cover flush with 2 in flight: flush_i pulse, then pc_i = 0x100 -> the 2 old responses are dropped and the first inst_pc_o = 0x100.
REQ-038 SHALL cover flush coincident with rvalid and with id_ready -> the returning word is dropped, drop_cnt = 1, and the buffer is empty next cycle.
REQ-039 SHALL cover misaligned pc_i = 0x0000_0006 -> imem_addr_o = 0x0000_0004 and inst_pc_o = 0x0000_0006.
REQ-040 SHALL cover rst_n asserted mid-fetch with 1 outstanding -> all outputs 0 immediately, and the first post-reset fetch behaves as in REQ-035.

Source files
------------

// File: rtl/if_fetch_pkg.sv
// Shared fetch-stage definitions: bus widths, reset level, buffer entry layout.
package if_fetch_pkg;

  localparam int InstAddrBus = 32;
  localparam int InstBus     = 32;

  localparam logic [InstAddrBus-1:0] ZeroAddr  = '0;
  localparam logic [InstBus-1:0]     ZeroWord  = '0;
  localparam logic                   RstEnable = 1'b0;

  // One instruction buffer entry: the fetch PC travels with its instruction word.
  typedef struct packed {
    logic [InstAddrBus-1:0] pc;
    logic [InstBus-1:0]     inst;
  } fetch_entry_t;

  // Instruction memory is word addressed; the low two address bits are dropped.
  function automatic logic [InstAddrBus-1:0] word_align(input logic [InstAddrBus-1:0] addr);
    return addr & ~InstAddrBus'(3);
  endfunction

endpackage

// File: rtl/if_fetch_if.sv
// Instruction memory request/response bus seen from the fetch stage.
interface if_fetch_if;
  import if_fetch_pkg::*;

  logic                   imem_req_o;
  logic [InstAddrBus-1:0] imem_addr_o;
  logic                   imem_gnt_i;
  logic                   imem_rvalid_i;
  logic [InstBus-1:0]     imem_rdata_i;

  // Fetch stage drives the request, memory answers with grant and in-order data.
  modport master (
    output imem_req_o,
    output imem_addr_o,
    input  imem_gnt_i,
    input  imem_rvalid_i,
    input  imem_rdata_i
  );

  modport slave (
    input  imem_req_o,
    input  imem_addr_o,
    output imem_gnt_i,
    output imem_rvalid_i,
    output imem_rdata_i
  );

endinterface

// File: rtl/if_fetch_fifo.sv
// Small synchronous FIFO used for both the tag queue and the instruction buffer.
// Head data is read combinationally; the caller never pushes when full or pops
// when empty. clr_i drops every entry on the next edge.
module fetch_fifo
  import if_fetch_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DEPTH = 2,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic [CNT_W-1:0] count_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;

  // Next pointers wrap explicitly at DEPTH-1; next count follows push/pop.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (clr_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_i) begin
        wr_ptr_d = (wr_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr_q + PTR_W'(1);
      end
      if (pop_i) begin
        rd_ptr_d = (rd_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr_q + PTR_W'(1);
      end
      if (push_i && !pop_i) begin
        count_d = count_q + CNT_W'(1);
      end else if (!push_i && pop_i) begin
        count_d = count_q - CNT_W'(1);
      end
    end
  end

  // Entry storage; contents are don't-care until written, so no reset.
  always_ff @(posedge clk) begin
    if (push_i && !clr_i) begin
      mem_q[wr_ptr_q] <= wdata_i;
    end
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (rst_n == RstEnable) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign rdata_o = mem_q[rd_ptr_q];
  assign count_o = count_q;

endmodule

// File: rtl/if_fetch.sv
// Instruction fetch stage. Issues one memory read per PC, tracks the PCs of
// in-flight reads in a tag queue, and queues returned instructions for decode.
// A shared credit (in-flight + buffered <= FIFO_DEPTH) guarantees every
// response has a buffer slot. On redirect the buffer is emptied and the
// responses still owed by memory are counted off and discarded as they return.
module if_fetch
  import if_fetch_pkg::*;
#(
  parameter int FIFO_DEPTH = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [InstAddrBus-1:0] pc_i,
  input  logic                   pc_valid_i,
  output logic                   pc_ready_o,
  if_fetch_if.master             imem,
  input  logic                   flush_i,
  output logic                   inst_valid_o,
  output logic [InstBus-1:0]     inst_o,
  output logic [InstAddrBus-1:0] inst_pc_o,
  input  logic                   id_ready_i
);

  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int SUM_W = CNT_W + 1;
  localparam logic [SUM_W-1:0] DEPTH_SUM = SUM_W'(FIFO_DEPTH);

  logic [CNT_W-1:0]       outstanding;
  logic [CNT_W-1:0]       buf_count;
  logic [CNT_W-1:0]       drop_cnt_q, drop_cnt_d;
  logic                   in_reset;
  logic                   req;
  logic                   grant;
  logic                   retire;
  logic                   buf_push;
  logic                   buf_pop;
  logic [InstAddrBus-1:0] tag_pc;
  fetch_entry_t           buf_wdata;
  fetch_entry_t           buf_head;

  // Request only while a buffer slot is still unclaimed; never while redirecting
  // or held in reset.
  assign in_reset = (rst_n == RstEnable);
  assign req      = pc_valid_i & ~flush_i & ~in_reset &
                    (({1'b0, outstanding} + {1'b0, buf_count}) < DEPTH_SUM);
  assign grant    = req & imem.imem_gnt_i;

  assign imem.imem_req_o  = req;
  assign imem.imem_addr_o = word_align(pc_i);
  assign pc_ready_o       = grant;

  // A response with nothing in flight is a protocol violation and is ignored.
  assign retire   = imem.imem_rvalid_i & (outstanding != '0);
  // Responses owed to pre-redirect requests, or arriving with the redirect, are dropped.
  assign buf_push = retire & (drop_cnt_q == '0) & ~flush_i;
  // A redirect takes priority over decode accepting the head.
  assign buf_pop  = inst_valid_o & id_ready_i & ~flush_i;

  assign buf_wdata.pc   = tag_pc;
  assign buf_wdata.inst = imem.imem_rdata_i;

  // The tag queue occupancy is the in-flight count.
  fetch_fifo #(
    .WIDTH (InstAddrBus),
    .DEPTH (FIFO_DEPTH)
  ) u_tag_q (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr_i   (1'b0),
    .push_i  (grant),
    .wdata_i (pc_i),
    .pop_i   (retire),
    .rdata_o (tag_pc),
    .count_o (outstanding)
  );

  fetch_fifo #(
    .WIDTH ($bits(fetch_entry_t)),
    .DEPTH (FIFO_DEPTH)
  ) u_inst_buf (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr_i   (flush_i),
    .push_i  (buf_push),
    .wdata_i (buf_wdata),
    .pop_i   (buf_pop),
    .rdata_o (buf_head),
    .count_o (buf_count)
  );

  // On redirect every read still in flight after this cycle becomes stale
  // (no grant can happen in a redirect cycle); otherwise count stale ones off.
  always_comb begin
    drop_cnt_d = drop_cnt_q;
    if (flush_i) begin
      drop_cnt_d = outstanding - CNT_W'(retire);
    end else if (retire && (drop_cnt_q != '0)) begin
      drop_cnt_d = drop_cnt_q - CNT_W'(1);
    end
  end

  // Stale-response counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (rst_n == RstEnable) begin
      drop_cnt_q <= '0;
    end else begin
      drop_cnt_q <= drop_cnt_d;
    end
  end

  assign inst_valid_o = (buf_count != '0);
  assign inst_o       = inst_valid_o ? buf_head.inst : ZeroWord;
  assign inst_pc_o    = inst_valid_o ? buf_head.pc   : ZeroAddr;

endmodule
